// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: groups the requester-side handshake and the memory_controller
// command/response signals shared by sdram_arbiter and its surroundings.
//
// Handshake semantics (one place, applies to every requester lane i):
//   req_valid[i] is raised with req_we/req_addr/req_din/req_wdm lane i stable and held
//   until req_ready[i] pulses for exactly one cycle; the request is accepted in that
//   cycle. Dropping req_valid[i] before req_ready[i] withdraws the request silently.
//   rsp_valid[i] is a one-cycle pulse carrying read data on rsp_data; there is no
//   backpressure on responses. mc_read/mc_write/mc_refresh are one-cycle strobes and
//   the controller answers each one by raising mc_busy until the operation is done.
interface sdram_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*22-1:0] req_addr;
  logic [NUM_REQ*16-1:0] req_din;
  logic [NUM_REQ*2-1:0]  req_wdm;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_data;
  logic                  mc_read;
  logic                  mc_write;
  logic                  mc_refresh;
  logic [21:0]           mc_addr;
  logic [15:0]           mc_din;
  logic [1:0]            mc_wdm;
  logic [15:0]           mc_dout;
  logic                  mc_busy;

  // Arbiter side: consumes requests and controller status, drives grants and commands.
  modport slave (
    input  req_valid, req_we, req_addr, req_din, req_wdm, mc_dout, mc_busy,
    output req_ready, rsp_valid, rsp_data,
           mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm
  );

  // Fabric/controller side: issues requests and answers commands.
  modport master (
    output req_valid, req_we, req_addr, req_din, req_wdm, mc_dout, mc_busy,
    input  req_ready, rsp_valid, rsp_data,
           mc_read, mc_write, mc_refresh, mc_addr, mc_din, mc_wdm
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one memory_controller port among NUM_REQ requesters.
// Periodic auto-refresh has top priority; requesters are served round-robin.
// Every operation runs IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE, and all
// outputs are registered.
//
// Optional feature macro: SDRAM_ARB_FIXED_PRIO_EN
//   defined   : requester 0 wins whenever it is valid; round-robin only among 1..NUM_REQ-1
//   undefined : pure round-robin over all NUM_REQ requesters
// o_state exposes the FSM state (0 IDLE, 1 ISSUE, 2 WAIT_BUSY, 3 WAIT_DONE).
module sdram_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int REFRESH_CYCLES = 420
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_arbiter_if.slave       bus,
  output logic                 refresh_overrun,
  output logic                 protocol_err,
  output logic [1:0]           o_state
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2
  } op_e;

  // FSM and latched operation
  state_e             r_state,     w_state_nxt;
  op_e                r_op,        w_op_nxt;
  logic [PTR_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [PTR_W-1:0]   r_owner,     w_owner_nxt;
  logic [21:0]        r_addr,      w_addr_nxt;
  logic [15:0]        r_din,       w_din_nxt;
  logic [1:0]         r_wdm,       w_wdm_nxt;
  logic               r_wait,      w_wait_nxt;

  // Registered outputs
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic [NUM_REQ-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0]        r_rsp_data,  w_rsp_data_nxt;
  logic               r_mc_read,   w_mc_read_nxt;
  logic               r_mc_write,  w_mc_write_nxt;
  logic               r_mc_refresh, w_mc_refresh_nxt;
  logic               r_protocol_err, w_protocol_err_nxt;

  // Refresh timer
  logic [CNT_W-1:0]   r_ref_cnt;
  logic               r_ref_pending;
  logic               r_refresh_overrun;
  logic               w_ref_wrap;
  logic               w_ref_take;

  // Arbitration result
  logic               w_any_valid;
  logic [PTR_W-1:0]   w_winner;

  // Requester index reached by stepping 'step' places past 'base', wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int               step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  assign w_ref_wrap = (r_ref_cnt == CNT_LAST);

  // Refresh interval counter; a wrap posts a refresh, a wrap on an unserved one is an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt         <= '0;
      r_ref_pending     <= 1'b0;
      r_refresh_overrun <= 1'b0;
    end else begin
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
      if (w_ref_wrap) begin
        r_ref_pending <= 1'b1;
        if (r_ref_pending && !w_ref_take) r_refresh_overrun <= 1'b1;
      end else if (w_ref_take) begin
        r_ref_pending <= 1'b0;
      end
    end
  end

  // Winner search: starts one past the last winner; requester 0 may jump the queue.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    if (FIXED_PRIO && bus.req_valid[0]) begin
      w_any_valid = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!w_any_valid && bus.req_valid[rr_index(r_rr_ptr, k)] &&
            !(FIXED_PRIO && (rr_index(r_rr_ptr, k) == '0))) begin
          w_any_valid = 1'b1;
          w_winner    = rr_index(r_rr_ptr, k);
        end
      end
    end
  end

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_op_nxt           = r_op;
    w_rr_ptr_nxt       = r_rr_ptr;
    w_owner_nxt        = r_owner;
    w_addr_nxt         = r_addr;
    w_din_nxt          = r_din;
    w_wdm_nxt          = r_wdm;
    w_wait_nxt         = r_wait;
    w_req_ready_nxt    = '0;
    w_rsp_valid_nxt    = '0;
    w_rsp_data_nxt     = r_rsp_data;
    w_mc_read_nxt      = 1'b0;
    w_mc_write_nxt     = 1'b0;
    w_mc_refresh_nxt   = 1'b0;
    w_protocol_err_nxt = r_protocol_err;
    w_ref_take         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A busy controller (power-up init or an op left over from reset) blocks issue.
        if (!bus.mc_busy) begin
          if (r_ref_pending) begin
            w_ref_take  = 1'b1;
            w_op_nxt    = OP_REFRESH;
            w_state_nxt = S_ISSUE;
          end else if (w_any_valid) begin
            w_op_nxt                  = bus.req_we[w_winner] ? OP_WRITE : OP_READ;
            w_owner_nxt               = w_winner;
            w_rr_ptr_nxt              = w_winner;
            w_addr_nxt                = bus.req_addr[22*w_winner +: 22];
            w_din_nxt                 = bus.req_din[16*w_winner +: 16];
            w_wdm_nxt                 = bus.req_wdm[2*w_winner +: 2];
            w_req_ready_nxt[w_winner] = 1'b1;
            w_state_nxt               = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        w_mc_read_nxt    = (r_op == OP_READ);
        w_mc_write_nxt   = (r_op == OP_WRITE);
        w_mc_refresh_nxt = (r_op == OP_REFRESH);
        w_wait_nxt       = 1'b0;
        w_state_nxt      = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        // The controller gets two cycles to acknowledge the strobe with mc_busy.
        if (bus.mc_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_wait) begin
          w_protocol_err_nxt = 1'b1;
          w_state_nxt        = S_IDLE;
        end else begin
          w_wait_nxt = 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!bus.mc_busy) begin
          w_state_nxt = S_IDLE;
          if (r_op == OP_READ) begin
            w_rsp_data_nxt           = bus.mc_dout;
            w_rsp_valid_nxt[r_owner] = 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched operation and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= OP_READ;
      r_rr_ptr       <= PTR_INIT;
      r_owner        <= '0;
      r_addr         <= '0;
      r_din          <= '0;
      r_wdm          <= '0;
      r_wait         <= 1'b0;
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_mc_read      <= 1'b0;
      r_mc_write     <= 1'b0;
      r_mc_refresh   <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op           <= w_op_nxt;
      r_rr_ptr       <= w_rr_ptr_nxt;
      r_owner        <= w_owner_nxt;
      r_addr         <= w_addr_nxt;
      r_din          <= w_din_nxt;
      r_wdm          <= w_wdm_nxt;
      r_wait         <= w_wait_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_data     <= w_rsp_data_nxt;
      r_mc_read      <= w_mc_read_nxt;
      r_mc_write     <= w_mc_write_nxt;
      r_mc_refresh   <= w_mc_refresh_nxt;
      r_protocol_err <= w_protocol_err_nxt;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.mc_read     = r_mc_read;
  assign bus.mc_write    = r_mc_write;
  assign bus.mc_refresh  = r_mc_refresh;
  assign bus.mc_addr     = r_addr;
  assign bus.mc_din      = r_din;
  assign bus.mc_wdm      = r_wdm;
  assign refresh_overrun = r_refresh_overrun;
  assign protocol_err    = r_protocol_err;
  assign o_state         = r_state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter. Instance A (REFRESH_CYCLES=420,
// refresh never due inside a test) covers grant, latency, round-robin, protocol error
// and reset behaviour; instance B (REFRESH_CYCLES=20) covers refresh scheduling.
// Each DUT gets a small controller model: busy for 4 cycles starting the cycle after a strobe.
module tb_sdram_arbiter;
  localparam int NUM_REQ = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_arbiter_if #(.NUM_REQ(NUM_REQ)) ifa ();
  sdram_arbiter_if #(.NUM_REQ(NUM_REQ)) ifb ();

  logic       a_overrun, a_perr, b_overrun, b_perr;
  logic [1:0] a_state, b_state;

  sdram_arbiter #(.NUM_REQ(NUM_REQ), .REFRESH_CYCLES(420)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .refresh_overrun(a_overrun), .protocol_err(a_perr), .o_state(a_state)
  );

  sdram_arbiter #(.NUM_REQ(NUM_REQ), .REFRESH_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .refresh_overrun(b_overrun), .protocol_err(b_perr), .o_state(b_state)
  );

  // ---------------- controller models ----------------
  logic [2:0]  a_cnt = 3'd0, b_cnt = 3'd0;
  logic        a_busy_op = 1'b0, b_busy_op = 1'b0;
  logic        a_force_busy = 1'b0, a_mute = 1'b0;
  logic [15:0] a_rdata = 16'h0, a_dout = 16'h0, b_dout = 16'h0;
  localparam logic [15:0] B_RDATA = 16'h0B0B;

  always @(posedge clk) begin
    if (a_cnt != 3'd0) begin
      a_cnt <= a_cnt - 3'd1;
      if (a_cnt == 3'd1) a_busy_op <= 1'b0;
    end else if (ifa.mc_read || ifa.mc_refresh || (ifa.mc_write && !a_mute)) begin
      a_cnt     <= 3'd4;
      a_busy_op <= 1'b1;
      if (ifa.mc_read) a_dout <= a_rdata;
    end
  end
  assign ifa.mc_busy = a_busy_op | a_force_busy;
  assign ifa.mc_dout = a_dout;

  always @(posedge clk) begin
    if (b_cnt != 3'd0) begin
      b_cnt <= b_cnt - 3'd1;
      if (b_cnt == 3'd1) b_busy_op <= 1'b0;
    end else if (ifb.mc_read || ifb.mc_refresh || ifb.mc_write) begin
      b_cnt     <= 3'd4;
      b_busy_op <= 1'b1;
      if (ifb.mc_read) b_dout <= B_RDATA;
    end
  end
  assign ifb.mc_busy = b_busy_op;
  assign ifb.mc_dout = b_dout;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_din = '0; ifa.req_wdm = '0;
    ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_din = '0; ifb.req_wdm = '0;
    a_force_busy = 1'b0;
    a_mute       = 1'b0;
  endtask

  // Returns at the negedge of "cycle 0": first cycle after the reset edge, reset now low.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 50 && (a_busy_op || b_busy_op); i++) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ifa.req_ready, ifa.rsp_valid, ifa.rsp_data, ifa.mc_read, ifa.mc_write, ifa.mc_refresh,
         ifa.mc_addr, ifa.mc_din, ifa.mc_wdm, a_overrun, a_perr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rsp=%b data=%h strobes=%b%b%b addr=%h ovr=%b perr=%b, want all 0",
               ifa.req_ready, ifa.rsp_valid, ifa.rsp_data, ifa.mc_read, ifa.mc_write,
               ifa.mc_refresh, ifa.mc_addr, a_overrun, a_perr);
    end
    n_checks++;
    if (a_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", a_state);
    end
  endtask

  task automatic test_busy_hold();
    do_reset();
    a_force_busy  = 1'b1;
    ifa.req_valid = 3'b001;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ifa.req_ready, ifa.mc_read, ifa.mc_write, ifa.mc_refresh} !== 6'b0) begin
        n_fail++;
        $display("FAIL busy_hold_quiet cycle %0d: ready=%b strobes=%b%b%b want 0",
                 i, ifa.req_ready, ifa.mc_read, ifa.mc_write, ifa.mc_refresh);
      end
    end
    a_force_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifa.req_ready !== 3'b001) begin
      n_fail++; $display("FAIL busy_hold_grant: got %b want 001", ifa.req_ready);
    end
    ifa.req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (ifa.mc_read !== 1'b1) begin
      n_fail++; $display("FAIL busy_hold_read: got %b want 1", ifa.mc_read);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_read();
    int t;
    do_reset();
    a_rdata              = 16'hBEEF;
    ifa.req_addr[21:0]   = 22'h12345;
    ifa.req_valid        = 3'b001;
    t = 0;
    do begin @(negedge clk); t++; end while (ifa.req_ready == '0 && t < 20);
    n_checks++;
    if (ifa.req_ready !== 3'b001 || t != 1) begin
      n_fail++; $display("FAIL read_grant: ready=%b after %0d cycles, want 001 after 1", ifa.req_ready, t);
    end
    ifa.req_valid = '0;
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      case (d)
        1: begin
          n_checks++;
          if ({ifa.mc_read, ifa.mc_write, ifa.mc_refresh} !== 3'b100 || ifa.mc_addr !== 22'h12345) begin
            n_fail++;
            $display("FAIL read_issue: strobes=%b%b%b addr=%h want 100 addr=12345",
                     ifa.mc_read, ifa.mc_write, ifa.mc_refresh, ifa.mc_addr);
          end
        end
        7: begin
          n_checks++;
          if (ifa.rsp_valid !== 3'b001 || ifa.rsp_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL read_rsp: valid=%b data=%h want 001 beef", ifa.rsp_valid, ifa.rsp_data);
          end
        end
        default: begin
          n_checks++;
          if (ifa.rsp_valid !== 3'b000 || ifa.mc_read !== 1'b0) begin
            n_fail++; $display("FAIL read_quiet T+%0d: rsp=%b read=%b want 0", d, ifa.rsp_valid, ifa.mc_read);
          end
        end
      endcase
    end
  endtask

  task automatic test_write();
    logic rsp_seen;
    do_reset();
    ifa.req_we[1]         = 1'b1;
    ifa.req_addr[22 +: 22] = 22'h3ABCDE;
    ifa.req_din[16 +: 16]  = 16'hA5A5;
    ifa.req_wdm[2 +: 2]    = 2'b10;
    ifa.req_valid         = 3'b010;
    @(negedge clk);
    n_checks++;
    if (ifa.req_ready !== 3'b010) begin
      n_fail++; $display("FAIL write_grant: got %b want 010", ifa.req_ready);
    end
    ifa.req_valid = '0;
    rsp_seen = 1'b0;
    for (int d = 1; d <= 9; d++) begin
      @(negedge clk);
      if (ifa.rsp_valid != '0) rsp_seen = 1'b1;
      if (d == 1) begin
        n_checks++;
        if ({ifa.mc_read, ifa.mc_write, ifa.mc_refresh} !== 3'b010 || ifa.mc_addr !== 22'h3ABCDE ||
            ifa.mc_din !== 16'hA5A5 || ifa.mc_wdm !== 2'b10) begin
          n_fail++;
          $display("FAIL write_issue: strobes=%b%b%b addr=%h din=%h wdm=%b want 010 3abcde a5a5 10",
                   ifa.mc_read, ifa.mc_write, ifa.mc_refresh, ifa.mc_addr, ifa.mc_din, ifa.mc_wdm);
        end
      end
      if (d == 7) begin
        n_checks++;
        if (a_state !== 2'd0) begin
          n_fail++; $display("FAIL write_idle: state=%0d want 0", a_state);
        end
      end
    end
    n_checks++;
    if (rsp_seen !== 1'b0) begin
      n_fail++; $display("FAIL write_no_rsp: rsp_valid seen=%b want 0", rsp_seen);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_q[$];
    int         gap;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    exp_q = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    do_reset();
    ifa.req_valid = 3'b111;
    for (int g = 0; g < 6; g++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (ifa.req_ready == '0 && gap < 30);
      n_checks++;
      if (ifa.req_ready !== exp_q[g]) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, ifa.req_ready, exp_q[g]);
      end
      if (g > 0) begin
        n_checks++;
        if (gap != 8) begin
          n_fail++; $display("FAIL rr_gap%0d: got %0d cycles want 8", g, gap);
        end
      end
    end
    ifa.req_valid = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_refresh();
    int exp_q[$];
    int got_q[$];
    int n_rsp;
    exp_q = '{26, 42, 66, 82, 106, 122};
    n_rsp = 0;
    do_reset();
    ifb.req_valid = 3'b001;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (ifb.mc_refresh) got_q.push_back(c);
      if (ifb.rsp_valid != '0) n_rsp++;
      if (c == 25) begin
        n_checks++;
        if (ifb.req_ready !== 3'b000) begin
          n_fail++; $display("FAIL refresh_first: ready=%b at cycle 25, want 000", ifb.req_ready);
        end
      end
    end
    ifb.req_valid = '0;
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL refresh_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL refresh_time%0d: got cycle %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (n_rsp != 10 || ifb.rsp_data !== B_RDATA) begin
      n_fail++; $display("FAIL refresh_reads: rsp=%0d data=%h want 10 %h", n_rsp, ifb.rsp_data, B_RDATA);
    end
    n_checks++;
    if (b_overrun !== 1'b0 || b_perr !== 1'b0) begin
      n_fail++; $display("FAIL refresh_overrun: ovr=%b perr=%b want 0 0", b_overrun, b_perr);
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    a_mute        = 1'b1;
    ifa.req_we[0] = 1'b1;
    ifa.req_valid = 3'b001;
    @(negedge clk);
    ifa.req_valid = '0;
    for (int d = 1; d <= 6; d++) begin
      @(negedge clk);
      case (d)
        1: begin
          n_checks++;
          if (ifa.mc_write !== 1'b1 || a_state !== 2'd2) begin
            n_fail++; $display("FAIL perr_issue: write=%b state=%0d want 1 2", ifa.mc_write, a_state);
          end
        end
        2: begin
          n_checks++;
          if (a_perr !== 1'b0 || a_state !== 2'd2) begin
            n_fail++; $display("FAIL perr_early: perr=%b state=%0d want 0 2", a_perr, a_state);
          end
        end
        3: begin
          n_checks++;
          if (a_perr !== 1'b1 || a_state !== 2'd0) begin
            n_fail++; $display("FAIL perr_set: perr=%b state=%0d want 1 0", a_perr, a_state);
          end
        end
        6: begin
          n_checks++;
          if (a_perr !== 1'b1) begin
            n_fail++; $display("FAIL perr_sticky: perr=%b want 1", a_perr);
          end
        end
        default: ;
      endcase
    end
    do_reset();
    n_checks++;
    if (a_perr !== 1'b0) begin
      n_fail++; $display("FAIL perr_clear: perr=%b want 0", a_perr);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    a_rdata       = 16'h1234;
    ifa.req_valid = 3'b001;
    @(negedge clk);
    ifa.req_valid = '0;
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      case (d)
        3: begin
          n_checks++;
          if (a_state !== 2'd3) begin
            n_fail++; $display("FAIL midrst_wait_done: state=%0d want 3", a_state);
          end
          reset = 1'b1;
        end
        4: begin
          reset         = 1'b0;
          ifa.req_valid = 3'b001;
          n_checks++;
          if (a_state !== 2'd0 || ifa.rsp_valid !== 3'b000) begin
            n_fail++; $display("FAIL midrst_idle: state=%0d rsp=%b want 0 000", a_state, ifa.rsp_valid);
          end
        end
        5, 6: begin
          n_checks++;
          if (ifa.req_ready !== 3'b000 || ifa.rsp_valid !== 3'b000 || ifa.mc_read !== 1'b0) begin
            n_fail++; $display("FAIL midrst_hold T+%0d: ready=%b rsp=%b read=%b want 0",
                               d, ifa.req_ready, ifa.rsp_valid, ifa.mc_read);
          end
        end
        7: begin
          ifa.req_valid = '0;
          n_checks++;
          if (ifa.req_ready !== 3'b001 || ifa.rsp_valid !== 3'b000) begin
            n_fail++; $display("FAIL midrst_regrant: ready=%b rsp=%b want 001 000", ifa.req_ready, ifa.rsp_valid);
          end
        end
        8: begin
          n_checks++;
          if (ifa.mc_read !== 1'b1) begin
            n_fail++; $display("FAIL midrst_reissue: read=%b want 1", ifa.mc_read);
          end
        end
        default: ;
      endcase
    end
    repeat (10) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_busy_hold();
    test_single_read();
    test_write();
    test_round_robin();
    test_refresh();
    test_protocol_err();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
